// File: rtl/fighter_pkg.sv
// Shared types and helpers for the per-player fighter controller.
package fighter_pkg;

   localparam int POS_W = 10;
   localparam int HP_W  = 8;
   localparam int TMR_W = 4;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      WALK        = 3'd1,
      ATK_WINDUP  = 3'd2,
      ATK_ACTIVE  = 3'd3,
      ATK_RECOVER = 3'd4,
      HURT        = 3'd5,
      KO          = 3'd6
   } fstate_t;

   typedef enum logic [1:0] {
      DIR_NONE  = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_RIGHT = 2'd2
   } dir_t;

   // A zero duration would never reach the exit count, so it runs as one tick.
   function automatic logic [TMR_W-1:0] fr_norm(input logic [TMR_W-1:0] n);
      return (n == '0) ? TMR_W'(1) : n;
   endfunction

   function automatic logic [HP_W-1:0] hp_sub(
      input logic [HP_W-1:0] hp,
      input logic [HP_W-1:0] dmg
   );
      return (hp > dmg) ? (hp - dmg) : '0;
   endfunction

   function automatic dir_t decode_dir(input logic l, input logic r);
      dir_t d;
      d = DIR_NONE;
      if (l && !r) d = DIR_LEFT;
      if (r && !l) d = DIR_RIGHT;
      return d;
   endfunction

endpackage

// File: rtl/fighter_controller_timer.sv
// Loadable down-counter shared by every timed fighter state.
module frame_timer
   import fighter_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             tick,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic             done
);

   logic [TMR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (tick) begin
         if (load) begin
            cnt_d = fr_norm(load_val);
         end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TMR_W'(1);
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign done = (cnt_q == TMR_W'(1));

endmodule

// File: rtl/fighter_controller.sv
// Per-player motion/combat FSM: position, facing, HP, hitbox and sprite select.
module fighter_controller
   import fighter_pkg::*;
#(
   parameter logic [POS_W-1:0] X_MIN       = 10'd0,
   parameter logic [POS_W-1:0] X_MAX       = 10'd576,
   parameter logic [POS_W-1:0] X_INIT      = 10'd64,
   parameter logic             FACE_L_INIT = 1'b0,
   parameter logic [POS_W-1:0] SPEED       = 10'd4,
   parameter logic [TMR_W-1:0] WINDUP_FR   = 4'd4,
   parameter logic [TMR_W-1:0] ACTIVE_FR   = 4'd3,
   parameter logic [TMR_W-1:0] RECOVER_FR  = 4'd6,
   parameter logic [TMR_W-1:0] HURT_FR     = 4'd8,
   parameter logic [HP_W-1:0]  HP_INIT     = 8'd100,
   parameter logic [HP_W-1:0]  DMG         = 8'd10
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             frame_tick,
   input  logic             move_l,
   input  logic             move_r,
   input  logic             attack,
   input  logic             hit,
   output logic [POS_W-1:0] pos_x,
   output logic             facing_left,
   output logic [2:0]       fsm_state,
   output logic             attack_active,
   output logic [HP_W-1:0]  hp,
   output logic [1:0]       anim_frame,
   output logic             ko
);

   fstate_t          state_q, state_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic             face_q, face_d;
   logic [HP_W-1:0]  hp_q, hp_d;
   logic [1:0]       anim_q, anim_d;
   logic [2:0]       div_q, div_d;
   logic             hit_q, hit_d;
   logic             prev_q, prev_d;
   logic             act_q, act_d;
   logic             ko_q, ko_d;

   logic             tmr_load;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_done;

   logic             hit_pend;
   logic             press;
   dir_t             dir;
   logic [POS_W:0]   pos_l, pos_r;
   logic [HP_W-1:0]  hp_hit;

   frame_timer u_timer (
      .Clk      (Clk),
      .Reset    (Reset),
      .tick     (frame_tick),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // A hit arriving on the tick cycle itself is consumed by that tick.
   assign hit_pend = hit_q | hit;
   assign press    = attack & ~prev_q;
   assign dir      = decode_dir(move_l, move_r);
   assign pos_l    = {1'b0, pos_q} - {1'b0, SPEED};
   assign pos_r    = {1'b0, pos_q} + {1'b0, SPEED};
   assign hp_hit   = hp_sub(hp_q, DMG);

   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      face_d   = face_q;
      hp_d     = hp_q;
      hit_d    = hit_q | hit;
      prev_d   = prev_q;
      tmr_load = 1'b0;
      tmr_val  = '0;

      if (frame_tick) begin
         hit_d  = 1'b0;
         prev_d = attack;

         if (state_q == KO) begin
            state_d = KO;
         end else if (hit_pend) begin
            hp_d = hp_hit;
            if (hp_hit == '0) begin
               state_d = KO;
            end else begin
               state_d  = HURT;
               tmr_load = 1'b1;
               tmr_val  = HURT_FR;
            end
         end else begin
            case (state_q)
               IDLE, WALK: begin
                  if (press) begin
                     state_d  = ATK_WINDUP;
                     tmr_load = 1'b1;
                     tmr_val  = WINDUP_FR;
                  end else if (dir == DIR_LEFT) begin
                     state_d = WALK;
                     face_d  = 1'b1;
                     if (pos_l[POS_W] || pos_l[POS_W-1:0] < X_MIN)
                        pos_d = X_MIN;
                     else
                        pos_d = pos_l[POS_W-1:0];
                  end else if (dir == DIR_RIGHT) begin
                     state_d = WALK;
                     face_d  = 1'b0;
                     if (pos_r > {1'b0, X_MAX})
                        pos_d = X_MAX;
                     else
                        pos_d = pos_r[POS_W-1:0];
                  end else begin
                     state_d = IDLE;
                  end
               end
               ATK_WINDUP: begin
                  if (tmr_done) begin
                     state_d  = ATK_ACTIVE;
                     tmr_load = 1'b1;
                     tmr_val  = ACTIVE_FR;
                  end
               end
               ATK_ACTIVE: begin
                  if (tmr_done) begin
                     state_d  = ATK_RECOVER;
                     tmr_load = 1'b1;
                     tmr_val  = RECOVER_FR;
                  end
               end
               ATK_RECOVER, HURT: begin
                  if (tmr_done) state_d = IDLE;
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   // Sprite select follows the state being entered so it lines up with fsm_state.
   always_comb begin
      anim_d = anim_q;
      div_d  = div_q;
      if (frame_tick) begin
         anim_d = 2'd0;
         div_d  = 3'd0;
         case (state_d)
            WALK: begin
               if (state_q == WALK) begin
                  div_d  = div_q + 3'd1;
                  anim_d = (div_q == 3'd7) ? anim_q + 2'd1 : anim_q;
               end
            end
            ATK_WINDUP:  anim_d = 2'd1;
            ATK_ACTIVE:  anim_d = 2'd2;
            ATK_RECOVER: anim_d = 2'd3;
            default:     anim_d = 2'd0;
         endcase
      end
   end

   assign act_d = (state_d == ATK_ACTIVE);
   assign ko_d  = (state_d == KO);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         pos_q   <= X_INIT;
         face_q  <= FACE_L_INIT;
         hp_q    <= HP_INIT;
         anim_q  <= 2'd0;
         div_q   <= 3'd0;
         hit_q   <= 1'b0;
         prev_q  <= 1'b0;
         act_q   <= 1'b0;
         ko_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         face_q  <= face_d;
         hp_q    <= hp_d;
         anim_q  <= anim_d;
         div_q   <= div_d;
         hit_q   <= hit_d;
         prev_q  <= prev_d;
         act_q   <= act_d;
         ko_q    <= ko_d;
      end
   end

   assign pos_x         = pos_q;
   assign facing_left   = face_q;
   assign fsm_state     = state_q;
   assign attack_active = act_q;
   assign hp            = hp_q;
   assign anim_frame    = anim_q;
   assign ko            = ko_q;

endmodule
